// File: rtl/linked_list_fifo_drain.sv
// Drain stage for the shared-memory linked-list FIFO: round-robin pops into
// a 2-entry {id, data} output buffer feeding a valid/ready consumer stream.
module linked_list_fifo_drain #(
  parameter int WIDTH     = 8,
  parameter int NUM_FIFOS = 2,
  parameter int ID_WIDTH  = $clog2(NUM_FIFOS)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_FIFOS-1:0] fifo_empty,
  input  logic [NUM_FIFOS-1:0] fifo_push,
  input  logic [WIDTH-1:0]     fifo_data,
  output logic [NUM_FIFOS-1:0] fifo_pop,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIDTH-1:0]     out_data,
  output logic [ID_WIDTH-1:0]  out_id
);

  typedef struct packed {
    logic [ID_WIDTH-1:0] id;
    logic [WIDTH-1:0]    data;
  } entry_t;

  entry_t              slot [2];
  logic                head, tail;
  logic [1:0]          count;
  logic [ID_WIDTH-1:0] rr_last, gnt_idx;
  logic                found, grant, deq;
  int                  cand;

  // Round-robin search: first non-empty FIFO after the last grant, wrapping.
  always_comb begin
    found   = 1'b0;
    gnt_idx = '0;
    cand    = 0;
    for (int k = 1; k <= NUM_FIFOS; k++) begin
      cand = int'(rr_last) + k;
      if (cand >= NUM_FIFOS) cand = cand - NUM_FIFOS;
      if (!found && !fifo_empty[ID_WIDTH'(cand)]) begin
        found   = 1'b1;
        gnt_idx = ID_WIDTH'(cand);
      end
    end
  end

  // Registered count keeps out_ready off the pop path; a push owns the port.
  assign grant    = !rst && (count != 2'd2) && !(|fifo_push) && found;
  assign fifo_pop = grant ? (NUM_FIFOS'(1) << gnt_idx) : '0;
  assign deq      = out_valid && out_ready;

  assign out_valid = (count != 2'd0);
  assign out_data  = slot[head].data;
  assign out_id    = slot[head].id;

  // Buffer capture/dequeue, occupancy count and arbiter pointer.
  always_ff @(posedge clk) begin
    if (rst) begin
      count   <= 2'd0;
      head    <= 1'b0;
      tail    <= 1'b0;
      rr_last <= ID_WIDTH'(NUM_FIFOS - 1);
      slot[0] <= '0;
      slot[1] <= '0;
    end else begin
      if (grant) begin
        slot[tail] <= '{id: gnt_idx, data: fifo_data};
        tail       <= ~tail;
        rr_last    <= gnt_idx;
      end
      if (deq) head <= ~head;
      case ({grant, deq})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_linked_list_fifo_drain.sv
// Directed bench: behavioural shared-FIFO model plus per-cycle expected values.
module tb_linked_list_fifo_drain;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] fifo_empty, fifo_push = 2'b00, fifo_pop;
  logic [7:0] fifo_data, pdata = 8'h00, out_data;
  logic       out_valid, out_ready = 1'b0;
  logic       out_id;

  int n_cmp = 0;
  int n_err = 0;

  // Shared FIFO model: registered empty flags, combinational read data.
  logic [7:0] mem [2][16];
  logic [3:0] wp [2] = '{4'd0, 4'd0};
  logic [3:0] rp [2] = '{4'd0, 4'd0};

  assign fifo_empty[0] = (wp[0] == rp[0]);
  assign fifo_empty[1] = (wp[1] == rp[1]);
  assign fifo_data     = fifo_pop[1] ? mem[1][rp[1]] : mem[0][rp[0]];

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (fifo_push[i]) begin
        mem[i][wp[i]] <= pdata;
        wp[i]         <= wp[i] + 4'd1;
      end
      if (fifo_pop[i]) rp[i] <= rp[i] + 4'd1;
    end
  end

  linked_list_fifo_drain #(.WIDTH(8), .NUM_FIFOS(2)) dut (
    .clk(clk), .rst(rst), .fifo_empty(fifo_empty), .fifo_push(fifo_push),
    .fifo_data(fifo_data), .fifo_pop(fifo_pop), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_id(out_id)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Drive one cycle's inputs at negedge, let combinational outputs settle.
  task automatic cyc(input logic r, input logic [1:0] push, input logic [7:0] d,
                     input logic rdy);
    @(negedge clk);
    rst = r; fifo_push = push; pdata = d; out_ready = rdy;
    #1;
  endtask

  // Expected pop vector and head entry for the current cycle.
  task automatic ex(input string tag, input logic [1:0] pop, input logic vld,
                    input logic [7:0] d, input logic id);
    chk({tag, ".pop"}, 32'(fifo_pop), 32'(pop));
    chk({tag, ".vld"}, 32'(out_valid), 32'(vld));
    if (vld) begin
      chk({tag, ".data"}, 32'(out_data), 32'(d));
      chk({tag, ".id"}, 32'(out_id), 32'(id));
    end
  endtask

  initial begin
    // Reset then idle
    cyc(1, 2'b00, 8'h00, 0);
    chk("rst0.pop", 32'(fifo_pop), 0);
    cyc(1, 2'b00, 8'h00, 0);
    ex("rst1", 2'b00, 0, 0, 0);
    chk("rst1.data", 32'(out_data), 0);
    chk("rst1.id", 32'(out_id), 0);
    cyc(0, 2'b00, 8'h00, 1);
    ex("idle", 2'b00, 0, 0, 0);

    // Single FIFO stream on FIFO 1; pushes block pops
    cyc(0, 2'b10, 8'h11, 1); ex("s.push0", 2'b00, 0, 0, 0);
    cyc(0, 2'b10, 8'h22, 1); ex("s.push1", 2'b00, 0, 0, 0);
    cyc(0, 2'b10, 8'h33, 1); ex("s.push2", 2'b00, 0, 0, 0);
    cyc(0, 2'b00, 8'h00, 1); ex("s.c0", 2'b10, 0, 0, 0);
    cyc(0, 2'b00, 8'h00, 1); ex("s.c1", 2'b10, 1, 8'h11, 1);
    cyc(0, 2'b00, 8'h00, 1); ex("s.c2", 2'b10, 1, 8'h22, 1);
    cyc(0, 2'b00, 8'h00, 1); ex("s.c3", 2'b00, 1, 8'h33, 1);
    cyc(0, 2'b00, 8'h00, 1); ex("s.c4", 2'b00, 0, 0, 0);

    // Round-robin fairness
    cyc(0, 2'b01, 8'hA0, 1);
    cyc(0, 2'b01, 8'hA1, 1);
    cyc(0, 2'b10, 8'hB0, 1);
    cyc(0, 2'b10, 8'hB1, 1); ex("rr.push", 2'b00, 0, 0, 0);
    cyc(0, 2'b00, 8'h00, 1); ex("rr.c0", 2'b01, 0, 0, 0);
    cyc(0, 2'b00, 8'h00, 1); ex("rr.c1", 2'b10, 1, 8'hA0, 0);
    cyc(0, 2'b00, 8'h00, 1); ex("rr.c2", 2'b01, 1, 8'hB0, 1);
    cyc(0, 2'b00, 8'h00, 1); ex("rr.c3", 2'b10, 1, 8'hA1, 0);
    cyc(0, 2'b00, 8'h00, 1); ex("rr.c4", 2'b00, 1, 8'hB1, 1);
    cyc(0, 2'b00, 8'h00, 1); ex("rr.c5", 2'b00, 0, 0, 0);

    // Backpressure: 4 words in FIFO 0, consumer stalled 5 cycles
    cyc(0, 2'b01, 8'hC0, 0);
    cyc(0, 2'b01, 8'hC1, 0);
    cyc(0, 2'b01, 8'hC2, 0);
    cyc(0, 2'b01, 8'hC3, 0);
    cyc(0, 2'b00, 8'h00, 0); ex("bp.s0", 2'b01, 0, 0, 0);
    cyc(0, 2'b00, 8'h00, 0); ex("bp.s1", 2'b01, 1, 8'hC0, 0);
    cyc(0, 2'b00, 8'h00, 0); ex("bp.s2", 2'b00, 1, 8'hC0, 0);
    cyc(0, 2'b00, 8'h00, 0); ex("bp.s3", 2'b00, 1, 8'hC0, 0);
    cyc(0, 2'b00, 8'h00, 0); ex("bp.s4", 2'b00, 1, 8'hC0, 0);
    cyc(0, 2'b00, 8'h00, 1); ex("bp.r0", 2'b00, 1, 8'hC0, 0);
    cyc(0, 2'b00, 8'h00, 1); ex("bp.r1", 2'b01, 1, 8'hC1, 0);
    cyc(0, 2'b00, 8'h00, 1); ex("bp.r2", 2'b01, 1, 8'hC2, 0);
    cyc(0, 2'b00, 8'h00, 1); ex("bp.r3", 2'b00, 1, 8'hC3, 0);
    cyc(0, 2'b00, 8'h00, 1); ex("bp.r4", 2'b00, 0, 0, 0);

    // Push collision: FIFO 0 ready to pop while FIFO 1 is being pushed
    cyc(0, 2'b01, 8'hD0, 1);
    cyc(0, 2'b10, 8'hE0, 1); ex("pc.coll", 2'b00, 0, 0, 0);
    cyc(0, 2'b00, 8'h00, 1); ex("pc.c0", 2'b10, 0, 0, 0);
    cyc(0, 2'b00, 8'h00, 1); ex("pc.c1", 2'b01, 1, 8'hE0, 1);
    cyc(0, 2'b00, 8'h00, 1); ex("pc.c2", 2'b00, 1, 8'hD0, 0);
    cyc(0, 2'b00, 8'h00, 1); ex("pc.c3", 2'b00, 0, 0, 0);

    // Reset mid-operation with a full buffer
    cyc(0, 2'b01, 8'h50, 0);
    cyc(0, 2'b01, 8'h51, 0);
    cyc(0, 2'b10, 8'h60, 0);
    cyc(0, 2'b10, 8'h61, 0);
    cyc(0, 2'b00, 8'h00, 0); ex("mr.p0", 2'b10, 0, 0, 0);
    cyc(0, 2'b00, 8'h00, 0); ex("mr.p1", 2'b01, 1, 8'h60, 1);
    cyc(0, 2'b00, 8'h00, 0); ex("mr.full", 2'b00, 1, 8'h60, 1);
    cyc(1, 2'b00, 8'h00, 0); chk("mr.rst.pop", 32'(fifo_pop), 0);
    cyc(0, 2'b00, 8'h00, 0); ex("mr.after", 2'b01, 0, 0, 0);
    chk("mr.after.data", 32'(out_data), 0);
    chk("mr.after.id", 32'(out_id), 0);
    cyc(0, 2'b00, 8'h00, 1); ex("mr.c0", 2'b10, 1, 8'h51, 0);
    cyc(0, 2'b00, 8'h00, 1); ex("mr.c1", 2'b00, 1, 8'h61, 1);
    cyc(0, 2'b00, 8'h00, 1); ex("mr.c2", 2'b00, 0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/linked_list_fifo_drain.md
# linked_list_fifo_drain

Downstream drain stage for the shared-memory linked-list FIFO. It watches the per-FIFO empty flags, issues one-hot pops in round-robin order, and captures the popped word with its source FIFO index into a 2-entry output buffer. The buffer drives a valid/ready stream to the consumer. Pops are never issued in a cycle where the upstream is pushing, because the shared FIFO supports only one push or pop per cycle.

## Interface
- WIDTH, 8, data width; matches the shared FIFO.
- NUM_FIFOS, 2, number of FIFOs; must be ≥2.
- ID_WIDTH, $clog2(NUM_FIFOS), width of the source-FIFO index.

- clk  input  1  clock; single clock domain, everything on posedge.
- rst  input  1  synchronous, active-high reset.
- fifo_empty  input  NUM_FIFOS  bit i = FIFO i empty (registered state of the shared FIFO).
- fifo_push  input  NUM_FIFOS  the push vector currently driven into the shared FIFO; any bit set inhibits popping this cycle.
- fifo_data  input  WIDTH  shared FIFO data_out; valid combinationally in the cycle fifo_pop is asserted.
- fifo_pop  output  NUM_FIFOS  zero or one-hot pop to the shared FIFO; combinational.
- out_valid  output  1  output buffer holds ≥1 entry.
- out_ready  input  1  consumer accepts the head entry when out_valid & out_ready.
- out_data  output  WIDTH  head entry data.
- out_id  output  ID_WIDTH  head entry source FIFO index.

## Operation
- State:
  - 2-entry buffer of {id, data}; head/tail slot pointers.
  - count in 0..2.
  - rr_last, the index last granted.
- Pop eligibility:
  - Eligible when rst = 0, count < 2, fifo_push = 0, and fifo_empty ≠ all ones.
  - The count < 2 test uses the registered count. There is no combinational path from out_ready to fifo_pop.
- Arbitration:
  - Search non-empty FIFOs starting at (rr_last+1) mod NUM_FIFOS, wrapping.
  - The first non-empty FIFO found is granted, and fifo_pop gets exactly that bit.
  - On a grant, rr_last <= granted index. With no grant, rr_last holds.
- Capture: on a grant, {granted index, fifo_data} is written at the tail in the same cycle, and the tail advances.
- Dequeue: when out_valid & out_ready, the head advances.
- count update:
  - +1 on grant only.
  - −1 on dequeue only.
  - Unchanged when both happen or neither happens.
- Ordering: entries leave in pop order. Per-FIFO order is preserved.
- Outputs: out_data/out_id show the head slot and are held stable while out_valid & ~out_ready.
- fifo_pop is never set for a FIFO whose fifo_empty bit is 1, and never has more than one bit set.

## Timing
- Reset (synchronous; the cycle after rst is sampled high):
  - count = 0, head = tail = 0, rr_last = NUM_FIFOS−1 (FIFO 0 has first priority).
  - out_valid = 0, out_data = 0, out_id = 0.
  - Buffer slots cleared to 0.
  - fifo_pop = 0 combinationally for the whole cycle rst is high.
- Reset mid-operation: buffered entries are discarded, and no pop is issued in the reset cycle.
- Latency:
  - Pop in cycle T → out_valid = 1 with that entry in cycle T+1, if the buffer was empty.
  - Min FIFO-to-consumer latency is 1 cycle.
- Throughput: with out_ready held high and no pushes, one pop and one dequeue every cycle in steady state (count holds at 1).
- Backpressure: with out_ready low, at most 2 pops occur. After that fifo_pop stays 0 until a dequeue drops count below 2. Popping resumes the cycle after that dequeue.
- Push collision: any cycle with |fifo_push = 1 has fifo_pop = 0. The arbiter state is unchanged that cycle.
- Empty change: fifo_empty is sampled combinationally each cycle. A FIFO that becomes non-empty is eligible in the first cycle its bit reads 0.

## Test plan
- Reset then idle: rst for 2 cycles, all FIFOs empty → fifo_pop = 0, out_valid = 0, out_data = 0, out_id = 0 throughout.
- Single FIFO stream (NUM_FIFOS = 2, WIDTH = 8):
  - Stimulus: push 0x11, 0x22, 0x33 to FIFO 1; then no pushes; out_ready = 1.
  - Response: fifo_pop = 2'b10 on 3 consecutive cycles; out_data sequence 0x11, 0x22, 0x33 with out_id = 1, each 1 cycle after its pop.
- Round-robin fairness:
  - Stimulus: FIFO 0 holds A0, A1; FIFO 1 holds B0, B1; out_ready = 1.
  - Response: pop order 0, 1, 0, 1; outputs A0, B0, A1, B1.
- Backpressure:
  - Stimulus: FIFO 0 holds 4 words; out_ready = 0 for 5 cycles, then 1.
  - Response: exactly 2 pops; out_data stable at word 0 while stalled; then all 4 words delivered in order with no loss or duplication.
- Push collision: a push asserted in the same cycle a pop is otherwise eligible → fifo_pop = 0 that cycle, and the pop occurs the next cycle with no push.
- Reset mid-operation: rst asserted while count = 2 → next cycle out_valid = 0, count = 0, and FIFO 0 has priority again.
